// File: rtl/button_press_conditioner.sv
// Two-channel pushbutton front end: 2-FF synchroniser, debouncer and rise detector per channel,
// plus an arbiter that never lets both press pulses fire together. Define AUTO_REPEAT_EN for held-key repeat.
module button_press_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 26,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic b1_raw,
    input  logic b2_raw,
    output logic b1_press,
    output logic b2_press,
    output logic b1_level,
    output logic b2_level
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 is channel 1, bit 1 is channel 2 throughout.
    logic [1:0]       raw;
    logic [1:0]       s1_q, s2_q;
    logic [1:0]       level_q, level_d;
    logic [CNT_W-1:0] db_cnt_q [2];
    logic [CNT_W-1:0] db_cnt_d [2];
    logic [1:0]       rise, rep_req, req;
    logic [1:0]       fire_d, press_q;
    logic [1:0]       pend_q, pend_d;

    assign raw = {b2_raw, b1_raw};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            level_d[c]  = level_q[c];
            db_cnt_d[c] = '0;
            if (s2_q[c] != level_q[c]) begin
                if (db_cnt_q[c] == DB_LAST) begin
                    level_d[c] = s2_q[c];
                end else begin
                    db_cnt_d[c] = db_cnt_q[c] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level_q <= '0;
            for (int c = 0; c < 2; c++) begin
                db_cnt_q[c] <= '0;
            end
        end else begin
            level_q <= level_d;
            for (int c = 0; c < 2; c++) begin
                db_cnt_q[c] <= db_cnt_d[c];
            end
        end
    end

    // Requests are taken from the next level so the registered pulse lands in the first level=1 cycle.
    assign rise = level_d & ~level_q;

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] dly_q [2];
    logic [CNT_W-1:0] dly_d [2];
    logic [CNT_W-1:0] per_q [2];
    logic [CNT_W-1:0] per_d [2];

    // The delay counter saturates at its last value; the period counter then supplies the repeat phase.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            dly_d[c]   = '0;
            per_d[c]   = '0;
            rep_req[c] = 1'b0;
            if (level_q[c]) begin
                if (dly_q[c] != RD_LAST) begin
                    dly_d[c] = dly_q[c] + CNT_W'(1);
                end else begin
                    dly_d[c]   = dly_q[c];
                    per_d[c]   = (per_q[c] == RP_LAST) ? '0 : per_q[c] + CNT_W'(1);
                    rep_req[c] = level_d[c] && (per_q[c] == '0);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < 2; c++) begin
                dly_q[c] <= '0;
                per_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                dly_q[c] <= dly_d[c];
                per_q[c] <= per_d[c];
            end
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign rep_req = '0;
`endif

    assign req = rise | rep_req;

    // A pended channel always wins; anything that cannot fire now waits in a one-deep flag.
    always_comb begin
        fire_d = '0;
        if (pend_q[0]) begin
            fire_d = 2'b01;
        end else if (pend_q[1]) begin
            fire_d = 2'b10;
        end else if (req[0]) begin
            fire_d = 2'b01;
        end else if (req[1]) begin
            fire_d = 2'b10;
        end
        pend_d = (pend_q | req) & ~fire_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press_q <= '0;
            pend_q  <= '0;
        end else begin
            press_q <= fire_d;
            pend_q  <= pend_d;
        end
    end

    assign b1_press = press_q[0];
    assign b2_press = press_q[1];
    assign b1_level = level_q[0];
    assign b2_level = level_q[1];

endmodule
